// File: rtl/clock_rate_controller.sv
// Programmable tick/square-wave timebase; tick registered, first tick div_active cycles after run is sampled.
// Divisor updates via valid/ready: ready drops while a new divisor waits for the next period boundary.
module clock_rate_controller #(
  parameter int                   CNT_WIDTH   = 27,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_DIV = CNT_WIDTH'(50_000_000)
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 cfg_valid,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  output logic                 tick,
  output logic                 square_out,
  output logic                 running
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] counter_q, counter_d;
  logic [CNT_WIDTH-1:0] div_active_q, div_active_d;
  logic [CNT_WIDTH-1:0] pend_div_q, pend_div_d;
  logic                 tick_q, tick_d;
  logic                 square_q, square_d;
  logic                 cfg_ready_q, cfg_ready_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 running_q, running_d;

  logic xfer;
  logic legal;
  logic wrap;

  assign xfer  = cfg_valid && cfg_ready_q;
  assign legal = (cfg_div >= CNT_WIDTH'(2));
  assign wrap  = (counter_q == (div_active_q - CNT_WIDTH'(1)));

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    div_active_d = div_active_q;
    pend_div_d   = pend_div_q;
    tick_d       = 1'b0;
    square_d     = square_q;
    cfg_err_d    = xfer && !legal;

    unique case (state_q)
      IDLE: begin
        counter_d = '0;
        if (xfer && legal) div_active_d = cfg_div;
        if (run) state_d = RUN;
      end
      RUN: begin
        if (!run) begin
          // Stopping takes priority over a coincident wrap: no tick on the stop edge.
          state_d   = IDLE;
          counter_d = '0;
          if (xfer && legal) div_active_d = cfg_div;
        end else begin
          if (wrap) begin
            counter_d = '0;
            tick_d    = 1'b1;
            square_d  = ~square_q;
          end else begin
            counter_d = counter_q + CNT_WIDTH'(1);
          end
          if (xfer && legal) begin
            pend_div_d = cfg_div;
            state_d    = PEND;
          end
        end
      end
      PEND: begin
        if (!run) begin
          state_d      = IDLE;
          counter_d    = '0;
          div_active_d = pend_div_q;
        end else if (wrap) begin
          counter_d    = '0;
          tick_d       = 1'b1;
          square_d     = ~square_q;
          div_active_d = pend_div_q;
          state_d      = RUN;
        end else begin
          counter_d = counter_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = '0;
      end
    endcase

    cfg_ready_d = (state_d != PEND);
    running_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      div_active_q <= DEFAULT_DIV;
      pend_div_q   <= '0;
      tick_q       <= 1'b0;
      square_q     <= 1'b0;
      cfg_ready_q  <= 1'b1;
      cfg_err_q    <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      div_active_q <= div_active_d;
      pend_div_q   <= pend_div_d;
      tick_q       <= tick_d;
      square_q     <= square_d;
      cfg_ready_q  <= cfg_ready_d;
      cfg_err_q    <= cfg_err_d;
      running_q    <= running_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign cfg_err    = cfg_err_q;
  assign tick       = tick_q;
  assign square_out = square_q;
  assign running    = running_q;

endmodule

// File: doc/clock_rate_controller.md
# clock_rate_controller

Run-time controller for the board's clock-division datapath. It produces a one-cycle clock-enable `tick` and a 50 %-duty `square_out` at a programmable rate, and accepts new divisor values through a valid/ready handshake. A new divisor takes effect only at a period boundary, so rate changes never produce truncated or runt periods. It sits between the user/FSM logic (calculator, display scan, debouncers) and every consumer of a slow timebase, and replaces hard-wired divider constants.

## Interface
- `CNT_WIDTH`, 27: width of divisor and internal counter.
- `DEFAULT_DIV`, 50_000_000: divisor loaded at reset; must be ≥ 2 and < 2^CNT_WIDTH.
- `clk_in` in 1: system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `run` in 1: level; 1 = generate ticks, 0 = stopped.
- `cfg_valid` in 1: new divisor offered.
- `cfg_div` in CNT_WIDTH: offered divisor, in clk_in cycles per tick.
- `cfg_ready` out 1: controller can accept a divisor.
- `cfg_err` out 1: one-cycle pulse; the accepted divisor was rejected (< 2).
- `tick` out 1: one-cycle enable pulse, once per active period.
- `square_out` out 1: toggles on every tick; period is 2·div_active.
- `running` out 1: high in RUN or PEND.

## Operation
- State `div_active` holds the current divisor; `counter` holds CNT_WIDTH bits; `pend_div` holds the stored divisor.
- FSM states:
  - IDLE: stopped; `counter` held at 0.
  - RUN: counting.
  - PEND: counting, with a valid divisor waiting in `pend_div`.
- Transitions:
  - IDLE→RUN when `run`=1; `counter` starts from 0.
  - RUN/PEND→IDLE when `run`=0. In PEND, `pend_div` is copied to `div_active` on this same edge.
  - RUN→PEND on an accepted, legal transfer.
  - PEND→RUN at the wrap edge, with `div_active`←`pend_div`.
- Counting: `counter` increments every cycle in RUN/PEND. At `counter`==`div_active`−1 (the wrap), `counter`←0, `tick`←1 for one cycle, and `square_out`←~`square_out`.
- Handshake:
  - `cfg_ready` = 1 in IDLE and RUN; 0 in PEND.
  - A transfer occurs on an edge where `cfg_valid`&&`cfg_ready`.
  - `cfg_div` < 2 is illegal: it is consumed, `cfg_err` pulses on the next cycle, and state and divisor are unchanged.
- Transfer in IDLE: `div_active`←`cfg_div` immediately; the state stays IDLE.
- Transfer in RUN, on the same edge as a wrap: the wrap completes with the old divisor. `cfg_div` is stored and the state goes to PEND, so the new divisor applies at the following wrap.
- Transfer on the same edge that `run` falls: `div_active`←`cfg_div`, state → IDLE.
- `square_out` holds its level in IDLE; it is cleared only by reset.
- Arithmetic: the counter compare is unsigned; `counter` never exceeds `div_active`−1. Divisor 2^CNT_WIDTH−1 is legal.

## Timing
- Reset values, asserted asynchronously:
  - IDLE, `counter`=0, `div_active`=DEFAULT_DIV.
  - `tick`=0, `square_out`=0, `cfg_ready`=1, `cfg_err`=0, `running`=0.
- All outputs are registered.
- First tick: `run` is sampled high at edge E0; `tick` is high in the cycle after edge E0+div_active. Subsequent ticks are exactly div_active cycles apart.
- `running` rises one cycle after `run` is sampled high and falls one cycle after `run` is sampled low.
- `cfg_err` rises one cycle after the rejecting transfer edge and lasts exactly one cycle.
- Rate-change latency in RUN: the new period starts at the first wrap after acceptance; no period is shortened or lengthened.
- Reset mid-period or in PEND: `pend_div` is discarded and all reset values are restored immediately. After release, the first tick arrives DEFAULT_DIV cycles after `run` is sampled.

## Test plan
- Bench uses DEFAULT_DIV=4, CNT_WIDTH=8. Release reset and hold `run`=1 → `tick` every 4 cycles; `square_out` period 8; `running`=1.
- Running at div 4, transfer `cfg_div`=6 mid-period → the current period stays 4 cycles, then periods of 6; `cfg_ready`=0 until that wrap.
- Transfer `cfg_div`=1, then `cfg_div`=0 → one `cfg_err` pulse per transfer; tick period stays 4.
- In IDLE, transfer 3, then raise `run` → first `tick` 3 cycles after `run` is sampled.
- In PEND with div 5 stored, drop `run` → IDLE; `div_active`=5; `square_out` frozen; restarting gives a 5-cycle period.
- Assert `reset` asynchronously mid-period → outputs take reset values before the next edge. Transfer on the same edge as a wrap → the old period completes, one more old period follows, then the new period.
